// File: rtl/coax_tx_if.sv
// FIFO read-side bundle between the host FIFO and the coax transmitter.
interface coax_tx_if #(
    parameter int WIDTH = 10
);
    logic             fifo_state;
    logic [WIDTH-1:0] fifo_read;
    logic             fifo_ren;

    modport master (input fifo_state, input fifo_read, output fifo_ren);
    modport slave  (output fifo_state, output fifo_read, input fifo_ren);
endinterface

// File: rtl/coax_tx.sv
// 3270 coax frame transmitter: pulls words from a show-ahead FIFO and sends
// line quiesce, code violation, sync/data/parity per word and the ending
// sequence, all biphase encoded with a registered line output.
//
// state | meaning
// IDLE  | line off, waiting for a non-empty FIFO
// LQ    | line-quiesce preamble, LQ_BITS '1' bits
// SCV   | start code violation, 3 half-bits high then 3 low
// SYNC  | word sync '1' bit
// DATA  | WIDTH data bits, MSB first
// PAR   | parity bit, makes data+parity ones even
// END0  | ending '0' bit
// ECV   | ending code violation, 2 half-bits high then 2 low
module coax_tx #(
    parameter int WIDTH    = 10,
    parameter int HALF_BIT = 10,
    parameter int LQ_BITS  = 5
) (
    input  logic      clk,
    input  logic      reset,
    coax_tx_if.master fifo,
    output logic      tx,
    output logic      tx_en,
    output logic      busy
);
    localparam int TW  = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam int HCW = $clog2(2 * LQ_BITS + 6);
    localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, LQ, SCV, SYNC, DATA, PAR, END0, ECV} state_t;

    state_t           state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [HCW-1:0]   half, half_n, last_half;
    logic [BW-1:0]    bit_idx, bit_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             par, par_n;
    logic             ren_n, tx_n;

    // Line level for a given half-bit of a given state; d is the bit being sent.
    function automatic logic level(state_t s, logic [HCW-1:0] h, logic d);
        logic v;
        v = 1'b0;
        case (s)
            LQ, SYNC:  v = ~h[0];
            SCV:       v = (h < HCW'(3));
            DATA, PAR: v = d ^ h[0];
            END0:      v = h[0];
            ECV:       v = (h < HCW'(2));
            default:   v = 1'b0;
        endcase
        return v;
    endfunction

    // Index of the final half-bit in the current state.
    always_comb begin
        last_half = HCW'(1);
        case (state)
            LQ:      last_half = HCW'(2 * LQ_BITS - 1);
            SCV:     last_half = HCW'(5);
            ECV:     last_half = HCW'(3);
            default: last_half = HCW'(1);
        endcase
    end

    // Next-state, counter and word-latch decisions; tx is precomputed for the next cycle.
    always_comb begin
        state_n = state;
        timer_n = timer;
        half_n  = half;
        bit_n   = bit_idx;
        shreg_n = shreg;
        par_n   = par;
        ren_n   = 1'b0;
        if (state == IDLE) begin
            if (fifo.fifo_state) begin
                state_n = LQ;
                timer_n = '0;
                half_n  = '0;
                bit_n   = '0;
                shreg_n = fifo.fifo_read;
                par_n   = ^fifo.fifo_read;
                ren_n   = 1'b1;
            end
        end else if (timer != TW'(HALF_BIT - 1)) begin
            timer_n = timer + 1'b1;
        end else begin
            timer_n = '0;
            if (half != last_half) begin
                half_n = half + 1'b1;
            end else begin
                half_n = '0;
                case (state)
                    LQ:   state_n = SCV;
                    SCV:  state_n = SYNC;
                    SYNC: begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                    DATA: begin
                        if (bit_idx == BW'(WIDTH - 1)) begin
                            state_n = PAR;
                        end else begin
                            bit_n   = bit_idx + 1'b1;
                            shreg_n = {shreg[WIDTH-2:0], 1'b0};
                        end
                    end
                    PAR: begin
                        // Only word boundary where the FIFO is looked at mid-frame.
                        if (fifo.fifo_state) begin
                            state_n = SYNC;
                            shreg_n = fifo.fifo_read;
                            par_n   = ^fifo.fifo_read;
                            ren_n   = 1'b1;
                        end else begin
                            state_n = END0;
                        end
                    end
                    END0:    state_n = ECV;
                    ECV:     state_n = IDLE;
                    default: state_n = IDLE;
                endcase
            end
        end
        tx_n = level(state_n, half_n, (state_n == PAR) ? par_n : shreg_n[WIDTH-1]);
    end

    // State, counters, word register and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            half          <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            par           <= 1'b0;
            tx            <= 1'b0;
            tx_en         <= 1'b0;
            fifo.fifo_ren <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            half          <= half_n;
            bit_idx       <= bit_n;
            shreg         <= shreg_n;
            par           <= par_n;
            tx            <= tx_n;
            tx_en         <= (state_n != IDLE);
            fifo.fifo_ren <= ren_n;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_coax_tx.sv
// Bench for coax_tx: two instances (HALF_BIT=2/LQ_BITS=5 and HALF_BIT=1/LQ_BITS=1)
// fed from bench FIFOs, compared every cycle against a half-bit level model.
module tb_coax_tx;
    logic clk = 1'b0;
    logic reset;
    logic tx0, en0, busy0, tx1, en1, busy1;

    coax_tx_if #(.WIDTH(10)) if0();
    coax_tx_if #(.WIDTH(10)) if1();

    coax_tx #(.WIDTH(10), .HALF_BIT(2), .LQ_BITS(5)) dut0 (
        .clk(clk), .reset(reset), .fifo(if0.master), .tx(tx0), .tx_en(en0), .busy(busy0));
    coax_tx #(.WIDTH(10), .HALF_BIT(1), .LQ_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .fifo(if1.master), .tx(tx1), .tx_en(en1), .busy(busy1));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    int hb[2], lqb[2];
    bit hl[2][4096];
    int hrd[2], hwr[2], cyc[2];
    bit act[2], wtail[2], ended[2], exp_ren[2], prev_en[2];

    logic [9:0] fq[2][256];
    int frd[2], fwr[2];
    int ren_cnt[2], en_cnt[2], frames[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic app(input int d, input bit v);
        hl[d][hwr[d]] = v;
        hwr[d]++;
    endtask

    // One biphase bit: '1' -> high,low ; '0' -> low,high.
    task automatic app_bit(input int d, input bit v);
        app(d, v);
        app(d, !v);
    endtask

    task automatic app_word(input int d, input logic [9:0] w);
        int ones;
        ones = 0;
        app_bit(d, 1'b1);
        for (int i = 9; i >= 0; i--) begin
            app_bit(d, w[i]);
            ones += int'(w[i]);
        end
        app_bit(d, (ones % 2) == 1);
        wtail[d] = 1'b1;
    endtask

    // Advance the reference model over one clock edge given pre-edge inputs.
    task automatic model_edge(input int d, input bit fs, input logic [9:0] hd, input bit rst);
        exp_ren[d] = 1'b0;
        ended[d]   = 1'b0;
        if (rst) begin
            act[d]   = 1'b0;
            wtail[d] = 1'b0;
        end else if (!act[d]) begin
            if (fs) begin
                hrd[d] = 0;
                hwr[d] = 0;
                for (int i = 0; i < lqb[d]; i++) app_bit(d, 1'b1);
                app(d, 1); app(d, 1); app(d, 1); app(d, 0); app(d, 0); app(d, 0);
                app_word(d, hd);
                act[d]     = 1'b1;
                cyc[d]     = 0;
                exp_ren[d] = 1'b1;
            end
        end else begin
            cyc[d]++;
            if (cyc[d] == hb[d]) begin
                cyc[d] = 0;
                hrd[d]++;
                if (hrd[d] == hwr[d]) begin
                    if (wtail[d]) begin
                        wtail[d] = 1'b0;
                        if (fs) begin
                            app_word(d, hd);
                            exp_ren[d] = 1'b1;
                        end else begin
                            app_bit(d, 1'b0);
                            app(d, 1); app(d, 1); app(d, 0); app(d, 0);
                            ended[d] = 1'b1;
                        end
                    end else begin
                        act[d] = 1'b0;
                    end
                end
            end
        end
    endtask

    // Show-ahead FIFO outputs; the head is junk while empty.
    task automatic drive_fifo();
        if0.fifo_state = (fwr[0] > frd[0]);
        if0.fifo_read  = if0.fifo_state ? fq[0][frd[0]] : 10'($urandom);
        if1.fifo_state = (fwr[1] > frd[1]);
        if1.fifo_read  = if1.fifo_state ? fq[1][frd[1]] : 10'($urandom);
    endtask

    task automatic push(input int d, input logic [9:0] w);
        fq[d][fwr[d]] = w;
        fwr[d]++;
        drive_fifo();
    endtask

    task automatic step();
        bit fs[2];
        logic [9:0] hd[2];
        bit ren[2];
        bit rst;
        logic o_tx[2], o_en[2], o_busy[2], o_ren[2];
        for (int d = 0; d < 2; d++) begin
            fs[d] = (fwr[d] > frd[d]);
            hd[d] = fq[d][frd[d]];
        end
        ren[0] = if0.fifo_ren;
        ren[1] = if1.fifo_ren;
        rst    = reset;
        @(posedge clk);
        #1;
        o_tx[0] = tx0;  o_en[0] = en0;  o_busy[0] = busy0;  o_ren[0] = if0.fifo_ren;
        o_tx[1] = tx1;  o_en[1] = en1;  o_busy[1] = busy1;  o_ren[1] = if1.fifo_ren;
        for (int d = 0; d < 2; d++) begin
            if (ren[d]) begin
                chk($sformatf("d%0d_ren_nonempty", d), 32'(fs[d]), 32'd1);
                if (fs[d]) frd[d]++;
                ren_cnt[d]++;
            end
            model_edge(d, fs[d], hd[d], rst);
        end
        drive_fifo();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_tx", d), 32'(o_tx[d]), 32'(act[d] ? hl[d][hrd[d]] : 1'b0));
            chk($sformatf("d%0d_tx_en", d), 32'(o_en[d]), 32'(act[d]));
            chk($sformatf("d%0d_busy", d), 32'(o_busy[d]), 32'(act[d]));
            chk($sformatf("d%0d_ren", d), 32'(o_ren[d]), 32'(exp_ren[d]));
            if (o_en[d] === 1'b1) en_cnt[d]++;
            if (o_en[d] === 1'b1 && !prev_en[d]) frames[d]++;
            prev_en[d] = (o_en[d] === 1'b1);
        end
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 2; d++) begin
            ren_cnt[d] = 0;
            en_cnt[d]  = 0;
            frames[d]  = 0;
        end
    endtask

    task automatic run_quiet(input string tag, input int budget);
        int n;
        n = 0;
        while ((act[0] || act[1] || fwr[0] > frd[0] || fwr[1] > frd[1]) && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
        step();
        step();
    endtask

    initial begin
        int n;
        hb[0] = 2;  lqb[0] = 5;
        hb[1] = 1;  lqb[1] = 1;
        for (int d = 0; d < 2; d++) begin
            hrd[d] = 0; hwr[d] = 0; cyc[d] = 0; frd[d] = 0; fwr[d] = 0;
            act[d] = 0; wtail[d] = 0; ended[d] = 0; exp_ren[d] = 0; prev_en[d] = 0;
        end
        clear_counts();
        reset = 1'b1;
        drive_fifo();

        // Reset held with words waiting: outputs quiet, no pops.
        push(0, 10'h2A5);
        push(1, 10'h000);
        repeat (3) step();
        chk("t1_no_pop0", 32'(ren_cnt[0]), 32'd0);
        chk("t1_no_pop1", 32'(ren_cnt[1]), 32'd0);

        // Single word frames: 0x2A5 at HALF_BIT=2, 0x000 at HALF_BIT=1/LQ_BITS=1.
        reset = 1'b0;
        clear_counts();
        run_quiet("t2", 2000);
        chk("t2_ren_pulses", 32'(ren_cnt[0]), 32'd1);
        chk("t2_tx_en_len", 32'(en_cnt[0]), 32'd92);
        chk("t6_ren_pulses", 32'(ren_cnt[1]), 32'd1);
        chk("t6_tx_en_len", 32'(en_cnt[1]), 32'd38);

        // Three queued words go out back to back in one frame.
        clear_counts();
        push(0, 10'h001);
        push(0, 10'h3FF);
        push(0, 10'h155);
        run_quiet("t3", 3000);
        chk("t3_ren_pulses", 32'(ren_cnt[0]), 32'd3);
        chk("t3_frames", 32'(frames[0]), 32'd1);
        chk("t3_tx_en_len", 32'(en_cnt[0]), 32'd188);

        // Second word arrives one cycle too late: two separate frames.
        clear_counts();
        push(0, 10'($urandom));
        n = 0;
        while (!ended[0] && n < 2000) begin
            step();
            n++;
        end
        chk("t4_end_seen", 32'(ended[0]), 32'd1);
        push(0, 10'($urandom));
        run_quiet("t4", 3000);
        chk("t4_frames", 32'(frames[0]), 32'd2);
        chk("t4_ren_pulses", 32'(ren_cnt[0]), 32'd2);

        // Reset in the middle of word 1 data; word 2 follows in a new frame.
        clear_counts();
        push(0, 10'($urandom));
        push(0, 10'($urandom));
        repeat (45) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_tx_after_rst", 32'(tx0), 32'd0);
        chk("t5_en_after_rst", 32'(en0), 32'd0);
        chk("t5_busy_after_rst", 32'(busy0), 32'd0);
        run_quiet("t5", 3000);
        chk("t5_frames", 32'(frames[0]), 32'd2);
        chk("t5_ren_pulses", 32'(ren_cnt[0]), 32'd2);
        chk("t5_fifo_drained", 32'(frd[0]), 32'(fwr[0]));

        // Random words with random gaps on both instances.
        for (int i = 0; i < 12; i++) begin
            push(int'($urandom_range(0, 1)), 10'($urandom));
            repeat ($urandom_range(0, 60)) step();
        end
        run_quiet("rand", 8000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
